// File: rtl/turbo_pkg.sv
// turbo_pkg: shared widths, interleaver tables and controller state encoding for ext_update
package turbo_pkg;
  localparam int DATA_SIZE = 10;
  localparam int SYS_SIZE = 4;
  localparam int EXTEND_SIZE = 7;
  localparam int EXT_W = DATA_SIZE * EXTEND_SIZE;
  localparam int SYS_W = SYS_SIZE * EXTEND_SIZE;
  localparam int PI [EXTEND_SIZE] = '{3, 6, 2, 5, 1, 4, 0};
  localparam int INV [EXTEND_SIZE] = '{6, 4, 2, 0, 5, 3, 1};
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_LLR, COMPUTE, DONE} state_t;
endpackage

// File: rtl/ext_update_if.sv
// ext_update_if: start/sys/llr inputs and sys/ext/valid/busy/iter/bits/done outputs of ext_update
interface ext_update_if;
  import turbo_pkg::*;
  logic start_i;
  logic [SYS_W-1:0] sys_i;
  logic llr_valid_i;
  logic [EXT_W-1:0] llr_i;
  logic [SYS_W-1:0] sys_o;
  logic [EXT_W-1:0] ext_o;
  logic ext_valid_o;
  logic busy_o;
  logic [3:0] iter_o;
  logic [EXTEND_SIZE-1:0] bits_o;
  logic done_o;
  modport slave (input start_i, sys_i, llr_valid_i, llr_i,
                 output sys_o, ext_o, ext_valid_o, busy_o, iter_o, bits_o, done_o);
  modport master (output start_i, sys_i, llr_valid_i, llr_i,
                  input sys_o, ext_o, ext_valid_o, busy_o, iter_o, bits_o, done_o);
endinterface

// File: rtl/sat_sub3.sv
// sat_sub3: y_o = sat(a_i - b_i - c_i), two guard bits then clamp to the signed W-bit range
module sat_sub3 #(parameter int W = 10) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [W-1:0] c_i,
  output logic [W-1:0] y_o
);
  logic [W+1:0] d;
  assign d = {{2{a_i[W-1]}}, a_i} - {{2{b_i[W-1]}}, b_i} - {{2{c_i[W-1]}}, c_i};
  assign y_o = (&d[W+1:W-1] | ~|d[W+1:W-1]) ? d[W-1:0] : {d[W+1], {(W-1){~d[W+1]}}};
endmodule

// File: rtl/ext_update.sv
// ext_update: turbo extrinsic-update controller; clk_i/reset_i plus ext_update_if slave bus (start/sys/llr in, sys/ext/valid/busy/iter/bits/done out)
module ext_update import turbo_pkg::*; #(
  parameter int MAX_ITER = 8
) (
  input logic clk_i,
  input logic reset_i,
  ext_update_if.slave bus
);
  state_t state_q, state_d;
  logic [SYS_W-1:0] sys_lat_q, sys_o_q, sys_perm;
  logic [EXT_W-1:0] ext_q, llr_q, e_w, ext_d;
  logic [EXTEND_SIZE-1:0] bits_q, bits_d;
  logic [4:0] h_q, h_inc;
  logic [3:0] iter_q;
  logic last;
  assign h_inc = h_q + 5'd1;
  assign last = h_inc == 5'(2 * MAX_ITER);
  for (genvar k = 0; k < EXTEND_SIZE; k++) begin : g_el
    localparam int P = PI[k];
    localparam int V = INV[k];
    logic [SYS_SIZE-1:0] s;
    assign s = sys_o_q[SYS_W-1-SYS_SIZE*k -: SYS_SIZE];
    sat_sub3 #(.W(DATA_SIZE)) u_sub (
      .a_i(llr_q[EXT_W-1-DATA_SIZE*k -: DATA_SIZE]),
      .b_i({{(DATA_SIZE-SYS_SIZE){s[SYS_SIZE-1]}}, s}),
      .c_i(ext_q[EXT_W-1-DATA_SIZE*k -: DATA_SIZE]),
      .y_o(e_w[EXT_W-1-DATA_SIZE*k -: DATA_SIZE])
    );
    assign ext_d[EXT_W-1-DATA_SIZE*k -: DATA_SIZE] = h_q[0] ? e_w[EXT_W-1-DATA_SIZE*V -: DATA_SIZE]
                                                             : e_w[EXT_W-1-DATA_SIZE*P -: DATA_SIZE];
    assign sys_perm[SYS_W-1-SYS_SIZE*k -: SYS_SIZE] = sys_lat_q[SYS_W-1-SYS_SIZE*P -: SYS_SIZE];
    assign bits_d[EXTEND_SIZE-1-k] = $signed(llr_q[EXT_W-1-DATA_SIZE*V -: DATA_SIZE]) > 0;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     state_d = bus.start_i ? ISSUE : IDLE;
      ISSUE:    state_d = WAIT_LLR;
      WAIT_LLR: state_d = bus.llr_valid_i ? COMPUTE : WAIT_LLR;
      COMPUTE:  state_d = last ? DONE : ISSUE;
      default:  state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      sys_lat_q <= '0;
      sys_o_q <= '0;
      ext_q <= '0;
      llr_q <= '0;
      bits_q <= '0;
      h_q <= '0;
      iter_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && bus.start_i) begin
        sys_lat_q <= bus.sys_i;
        sys_o_q <= bus.sys_i;
        ext_q <= '0;
        h_q <= '0;
        iter_q <= '0;
        bits_q <= '0;
      end
      if (state_q == WAIT_LLR && bus.llr_valid_i) llr_q <= bus.llr_i;
      if (state_q == COMPUTE) begin
        ext_q <= ext_d;
        h_q <= h_inc;
        iter_q <= h_inc[4:1];
        sys_o_q <= h_inc[0] ? sys_perm : sys_lat_q;
        if (last) bits_q <= bits_d;
      end
    end
  end
  assign bus.sys_o = sys_o_q;
  assign bus.ext_o = ext_q;
  assign bus.ext_valid_o = state_q == ISSUE;
  assign bus.busy_o = state_q != IDLE;
  assign bus.done_o = state_q == DONE;
  assign bus.iter_o = iter_q;
  assign bus.bits_o = bits_q;
endmodule

// File: tb/tb_ext_update.sv
// tb_ext_update: directed scoreboard bench for ext_update with MAX_ITER=2
module tb_ext_update;
  import turbo_pkg::*;
  typedef int arr7_t [7];
  typedef struct {
    logic is_done;
    logic [69:0] ext;
    logic [27:0] sys;
    logic [3:0] iter;
    logic [6:0] bits;
  } item_t;
  logic clk = 0;
  logic rst = 1;
  int total = 0;
  int passed = 0;
  item_t exp_q [$];
  item_t it;
  ext_update_if ifc ();
  ext_update #(.MAX_ITER(2)) dut (.clk_i(clk), .reset_i(rst), .bus(ifc.slave));
  always #5 clk = ~clk;
  function automatic logic [69:0] pk10(input arr7_t a);
    logic [69:0] v;
    for (int k = 0; k < 7; k++) v[69-10*k -: 10] = 10'(a[k]);
    return v;
  endfunction
  function automatic logic [27:0] pk4(input arr7_t a);
    logic [27:0] v;
    for (int k = 0; k < 7; k++) v[27-4*k -: 4] = 4'(a[k]);
    return v;
  endfunction
  task automatic chk(input string n, input logic [69:0] a, input logic [69:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s: got %h expected %h", n, a, e);
  endtask
  task automatic push_issue(input logic [69:0] e, input logic [27:0] s, input logic [3:0] i);
    exp_q.push_back('{1'b0, e, s, i, 7'd0});
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic start_blk(input logic [27:0] s);
    ifc.sys_i = s;
    ifc.start_i = 1;
    tick();
    ifc.start_i = 0;
    chk("start_latency", ifc.ext_valid_o, 1);
    tick();
  endtask
  task automatic feed(input logic [69:0] l);
    int n;
    ifc.llr_i = l;
    ifc.llr_valid_i = 1;
    tick();
    ifc.llr_valid_i = 0;
    ifc.llr_i = '0;
    chk("compute_busy", ifc.busy_o, 1);
    n = 0;
    while (!(ifc.ext_valid_o || ifc.done_o) && n < 10) begin
      tick();
      n++;
    end
    if (n == 10) begin
      total++;
      $display("FAIL timeout: no ext_valid_o/done_o within 10 cycles");
    end
    tick();
  endtask
  always @(negedge clk) begin
    if (ifc.ext_valid_o || ifc.done_o) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_out: ext_valid=%b done=%b with nothing expected", ifc.ext_valid_o, ifc.done_o);
      end else begin
        it = exp_q.pop_front();
        chk("out_kind", {ifc.ext_valid_o, ifc.done_o}, {~it.is_done, it.is_done});
        chk("out_busy", ifc.busy_o, 1);
        chk("out_iter", ifc.iter_o, it.iter);
        if (it.is_done) chk("done_bits", ifc.bits_o, it.bits);
        else begin
          chk("issue_ext", ifc.ext_o, it.ext);
          chk("issue_sys", ifc.sys_o, it.sys);
        end
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1);
  end
  initial begin
    logic [27:0] s, sp;
    ifc.start_i = 0;
    ifc.sys_i = '0;
    ifc.llr_valid_i = 0;
    ifc.llr_i = '0;
    repeat (2) tick();
    rst = 0;
    chk("rst_ext", ifc.ext_o, 0);
    chk("rst_sys", ifc.sys_o, 0);
    chk("rst_flags", {ifc.ext_valid_o, ifc.busy_o, ifc.done_o}, 0);
    chk("rst_iter_bits", {ifc.iter_o, ifc.bits_o}, 0);
    push_issue('0, '0, 0);
    start_blk('0);
    chk("wait_busy", ifc.busy_o, 1);
    rst = 1;
    tick();
    rst = 0;
    ifc.llr_i = pk10('{511, 511, 511, 511, 511, 511, 511});
    ifc.llr_valid_i = 1;
    tick();
    ifc.llr_valid_i = 0;
    repeat (3) tick();
    chk("midreset_flags", {ifc.ext_valid_o, ifc.busy_o, ifc.done_o}, 0);
    chk("midreset_data", {ifc.ext_o, ifc.sys_o}, 0);
    chk("midreset_iter_bits", {ifc.iter_o, ifc.bits_o}, 0);
    push_issue('0, '0, 0);
    ifc.start_i = 1;
    tick();
    ifc.start_i = 0;
    chk("start_latency", ifc.ext_valid_o, 1);
    ifc.llr_i = pk10('{1, 2, 3, 4, 5, 6, 7});
    ifc.llr_valid_i = 1;
    tick();
    ifc.llr_valid_i = 0;
    repeat (2) tick();
    chk("issue_llr_ignored", {ifc.busy_o, ifc.ext_valid_o, ifc.iter_o}, {1'b1, 1'b0, 4'd0});
    push_issue(pk10('{30, 60, 20, 50, 10, 40, 0}), '0, 0);
    feed(pk10('{0, 10, 20, 30, 40, 50, 60}));
    push_issue(pk10('{100, 90, 80, 70, 60, 50, 40}), '0, 1);
    feed(pk10('{100, 100, 100, 100, 100, 100, 100}));
    push_issue(pk10('{-70, -40, -80, -50, -90, -60, -100}), '0, 1);
    feed('0);
    exp_q.push_back('{1'b1, '0, '0, 4'd2, 7'b1111111});
    feed(pk10('{5, 5, 5, 5, 5, 5, 5}));
    chk("idle_after_done", {ifc.busy_o, ifc.done_o}, 0);
    s = pk4('{-8, 7, 1, 2, 3, 4, 5});
    sp = pk4('{2, 5, 1, 4, 7, 3, -8});
    push_issue('0, s, 0);
    start_blk(s);
    push_issue(pk10('{-2, -5, -1, -4, -512, -3, 511}), sp, 0);
    feed(pk10('{511, -512, 0, 0, 0, 0, 0}));
    push_issue(pk10('{-503, 511, 0, 0, 0, 0, 0}), s, 1);
    feed(pk10('{0, 0, 0, 0, 511, 0, 0}));
    push_issue(pk10('{-2, -5, -1, -4, -512, -3, 511}), sp, 1);
    feed('0);
    exp_q.push_back('{1'b1, '0, '0, 4'd2, 7'b0001110});
    feed(pk10('{1, 0, -1, 5, -5, 511, -512}));
    ifc.llr_i = pk10('{9, 9, 9, 9, 9, 9, 9});
    ifc.llr_valid_i = 1;
    tick();
    ifc.llr_valid_i = 0;
    repeat (2) tick();
    chk("idle_llr_ignored", {ifc.busy_o, ifc.ext_valid_o, ifc.done_o}, 0);
    chk("hold_iter_bits", {ifc.iter_o, ifc.bits_o}, {4'd2, 7'b0001110});
    push_issue('0, s, 0);
    start_blk(s);
    rst = 1;
    tick();
    rst = 0;
    repeat (3) tick();
    chk("drain", exp_q.size(), 0);
    chk("final_idle", {ifc.busy_o, ifc.iter_o, ifc.bits_o}, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
